// File: rtl/chunk_add_pkg.sv
// Shared types and helpers for the chunk-serial adder sequencer.
package chunk_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chunk_add_state_e;

    localparam int unsigned REQ_WIDTH = 32;

    // Operand request as presented by the upstream source.
    typedef struct packed {
        logic [REQ_WIDTH-1:0] a;
        logic [REQ_WIDTH-1:0] b;
        logic                 cin;
    } chunk_add_req_t;

    // Chunk index width; a single-chunk configuration still keeps a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_s,
    output logic             o_cout
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]   = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[CHUNK];

endmodule

// File: rtl/chunk_add_seq.sv
// Adds two WIDTH-bit operands one CHUNK-bit slice per cycle through a single shared adder.
// Optional subtract support is enabled by defining CHUNK_ADD_SUB_EN.
module chunk_add_seq
    import chunk_add_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef CHUNK_ADD_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_cfg_check
        $error("chunk_add_seq: WIDTH must be a multiple of CHUNK");
    end

    chunk_add_state_e r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic             w_sub;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_s;
    logic             w_cout;

`ifdef CHUNK_ADD_SUB_EN
    assign w_sub = in_sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_a_chunk = r_a[32'(r_idx) * CHUNK +: CHUNK];
    assign w_b_chunk = r_b[32'(r_idx) * CHUNK +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_adder (
        .i_a    (w_a_chunk),
        .i_b    (w_b_chunk),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    // Sequencer: accept in IDLE, one slice per RUN cycle, hold result in DONE until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        // Subtraction is A + ~B + 1, so the carry-in is forced high.
                        r_a      <= in_a;
                        r_b      <= w_sub ? ~in_b : in_b;
                        r_carry  <= w_sub ? 1'b1 : in_cin;
                        r_idx    <= '0;
                        r_state  <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    out_sum[32'(r_idx) * CHUNK +: CHUNK] <= w_s;
                    r_carry <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_state   <= DONE;
                        out_valid <= 1'b1;
                        out_cout  <= w_cout;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunk_add_seq.sv
// Self-checking bench for chunk_add_seq: cycle-level reference model plus directed and random traffic.
// Subtract cases are exercised when CHUNK_ADD_SUB_EN is defined.
`timescale 1ns/1ps
module tb_chunk_add_seq;

    localparam int unsigned W   = 32;
    localparam int unsigned C   = 8;
    localparam int          NCH = W / C;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        in_sub_s = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        busy;

    chunk_add_seq #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef CHUNK_ADD_SUB_EN
        .in_sub    (in_sub_s),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    // Single-chunk configuration instance.
    logic       r8 = 1'b1;
    logic       v8 = 1'b0;
    logic       rdy8;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       sub8 = 1'b0;
    logic       ov8;
    logic [7:0] sum8;
    logic       cout8;
    logic       busy8;

    chunk_add_seq #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk       (clk),
        .rst       (r8),
        .in_valid  (v8),
        .in_ready  (rdy8),
        .in_a      (a8),
        .in_b      (b8),
        .in_cin    (1'b0),
`ifdef CHUNK_ADD_SUB_EN
        .in_sub    (sub8),
`endif
        .out_valid (ov8),
        .out_ready (1'b1),
        .out_sum   (sum8),
        .out_cout  (cout8),
        .busy      (busy8)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
        return {1'b0, a} + {1'b0, b} + 33'(cin);
    endfunction

    // Reference model: an accepted request becomes visible NCH edges later and stays until taken.
    int          cyc = 0;
    bit          m_busy = 1'b0;
    int          m_valid_at = 0;
    logic [32:0] m_exp = '0;
    int          acc_cyc = 0;
    int          prev_acc = 0;

    always @(posedge clk) begin
        bit was_valid;
        cyc++;
        was_valid = m_busy && ((cyc - 1) >= m_valid_at);
        if (rst) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy     = 1'b1;
                m_valid_at = cyc + NCH;
                prev_acc   = acc_cyc;
                acc_cyc    = cyc;
                m_exp      = ref_add(in_a, in_b, in_cin, in_sub_s);
            end
        end else if (was_valid && out_ready) begin
            m_busy = 1'b0;
        end
    end

    // Per-cycle comparison against the model, plus capture of each result's first valid cycle.
    logic        prev_valid = 1'b0;
    logic [31:0] obs_sum = '0;
    logic        obs_cout = 1'b0;
    int          obs_lat = 0;

    always @(negedge clk) begin
        bit ev;
        ev = m_busy && (cyc >= m_valid_at);
        chk("in_ready", 64'(in_ready), 64'(!m_busy));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("out_valid", 64'(out_valid), 64'(ev));
        if (ev) begin
            chk("out_sum", 64'(out_sum), 64'(m_exp[31:0]));
            chk("out_cout", 64'(out_cout), 64'(m_exp[32]));
        end
        if (out_valid && !prev_valid) begin
            obs_sum  = out_sum;
            obs_cout = out_cout;
            obs_lat  = cyc - acc_cyc;
        end
        prev_valid = out_valid;
    end

    int bp_mode = 0;
    always @(posedge clk) begin
        #2;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            n_chk++;
            $display("FAIL %s_timeout: out_valid got 0 expected 1", name);
        end
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (m_busy && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (m_busy) begin
            n_chk++;
            $display("FAIL %s_idle_timeout: busy got 1 expected 0", name);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
        @(posedge clk);
        #2;
        in_a = a; in_b = b; in_cin = c; in_sub_s = s; in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #2;
        chk("rst_sum", 64'(out_sum), 64'h0);
        chk("rst_cout", 64'(out_cout), 64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        rst = 1'b0;

        // Wrap-around and latency
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        wait_valid("t1");
        chk("t1_sum", 64'(obs_sum), 64'h0);
        chk("t1_cout", 64'(obs_cout), 64'h1);
        chk("t1_latency", 64'(obs_lat), 64'd4);
        chk("t1_model_pin", 64'(m_exp), 64'h1_0000_0000);
        wait_idle("t1");

        // Carry-in, then a second request held pending until IDLE returns
        @(posedge clk);
        #2;
        in_a = 32'h1234_5678; in_b = 32'h1; in_cin = 1'b1; in_sub_s = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #2;
        chk("t2_ready_low", 64'(in_ready), 64'h0);
        in_a = 32'h10; in_b = 32'h20; in_cin = 1'b0;
        wait_valid("t2a");
        chk("t2a_sum", 64'(obs_sum), 64'h1234_567A);
        chk("t2a_cout", 64'(obs_cout), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        chk("t2_spacing", 64'(acc_cyc - prev_acc), 64'd6);
        wait_valid("t2b");
        chk("t2b_sum", 64'(obs_sum), 64'h30);
        wait_idle("t2");

        // Backpressure in DONE
        bp_mode = 2;
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        wait_valid("t3");
        chk("t3_sum", 64'(obs_sum), 64'h0);
        chk("t3_cout", 64'(obs_cout), 64'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 64'(out_valid), 64'h1);
            chk("t3_hold_busy", 64'(busy), 64'h1);
            chk("t3_hold_sum", 64'(out_sum), 64'h0);
            chk("t3_hold_cout", 64'(out_cout), 64'h1);
        end
        bp_mode = 0;
        wait_idle("t3");

        // Reset during the second RUN cycle
        @(posedge clk);
        #2;
        in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk("t4_ready", 64'(in_ready), 64'h1);
        chk("t4_valid", 64'(out_valid), 64'h0);
        chk("t4_busy", 64'(busy), 64'h0);
        send(32'd3, 32'd4, 1'b0, 1'b0);
        wait_valid("t4");
        chk("t4_sum", 64'(obs_sum), 64'd7);
        chk("t4_cout", 64'(obs_cout), 64'h0);
        wait_idle("t4");

        // in_valid pulse while running is ignored
        @(posedge clk);
        #2;
        in_a = 32'h100; in_b = 32'h200; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        wait_valid("t5");
        chk("t5_sum", 64'(obs_sum), 64'h300);
        wait_idle("t5");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_extra", 64'(out_valid), 64'h0);
        end

`ifdef CHUNK_ADD_SUB_EN
        send(32'd5, 32'd7, 1'b0, 1'b1);
        wait_valid("t6a");
        chk("t6a_sum", 64'(obs_sum), 64'hFFFF_FFFE);
        chk("t6a_cout", 64'(obs_cout), 64'h0);
        wait_idle("t6a");
        send(32'd7, 32'd5, 1'b1, 1'b1);
        wait_valid("t6b");
        chk("t6b_sum", 64'(obs_sum), 64'd2);
        chk("t6b_cout", 64'(obs_cout), 64'h1);
        wait_idle("t6b");
`endif

        // Random traffic with backpressure, busy pulses and occasional reset
        bp_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            in_valid = 1'($urandom_range(0, 1));
            in_a     = pick();
            in_b     = pick();
            in_cin   = 1'($urandom_range(0, 1));
`ifdef CHUNK_ADD_SUB_EN
            in_sub_s = 1'($urandom_range(0, 1));
`endif
            rst      = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst      = 1'b0;
        bp_mode  = 0;
        wait_idle("rand");

        // Single-chunk configuration: latency of one cycle
        @(posedge clk);
        #2;
        r8 = 1'b0;
        @(posedge clk);
        #2;
        chk("w8_ready", 64'(rdy8), 64'h1);
        a8 = 8'hFF; b8 = 8'h01; v8 = 1'b1;
        @(posedge clk);
        #2;
        v8 = 1'b0;
        chk("w8_run_valid", 64'(ov8), 64'h0);
        chk("w8_run_busy", 64'(busy8), 64'h1);
        @(posedge clk);
        #2;
        chk("w8_valid", 64'(ov8), 64'h1);
        chk("w8_sum", 64'(sum8), 64'h0);
        chk("w8_cout", 64'(cout8), 64'h1);
        @(posedge clk);
        #2;
        chk("w8_idle_valid", 64'(ov8), 64'h0);
        chk("w8_idle_ready", 64'(rdy8), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
